// File: rtl/rggen_rtl_pkg.sv
// ---------------------------------------------------------------------------
// rggen_rtl_pkg
//   Shared types for the rggen bit-field library.
//   rggen_rwsc_mode selects which side of a set/clear field is software:
//     RGGEN_SET_MODE   : software sets, hardware clears
//     RGGEN_CLEAR_MODE : hardware sets, software clears
// ---------------------------------------------------------------------------
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_SET_MODE   = 1'b0,
        RGGEN_CLEAR_MODE = 1'b1
    } rggen_rwsc_mode;

endpackage

// File: rtl/rggen_register_if.sv
// ---------------------------------------------------------------------------
// rggen_register_if
//   Register-level bus view shared between a register block and its fields.
//   Signals:
//     valid, write          : access strobe and direction from the host
//     write_data, write_mask: write payload and per-bit byte/bit enables
//     read_data             : value returned by the fields
//   write_access() is true for a valid write cycle.
//   Modports: host (drives the access), data (a bit field).
// ---------------------------------------------------------------------------
interface rggen_register_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  valid;
    logic                  write;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] write_mask;
    logic [DATA_WIDTH-1:0] read_data;

    // A field only reacts to accesses that are both valid and writes.
    function automatic logic write_access();
        return valid && write;
    endfunction

    modport host (
        output valid,
        output write,
        output write_data,
        output write_mask,
        input  read_data,
        import write_access
    );

    modport data (
        input  valid,
        input  write,
        input  write_data,
        input  write_mask,
        output read_data,
        import write_access
    );

endinterface

// File: rtl/rggen_saturating_counter.sv
// ---------------------------------------------------------------------------
// rggen_saturating_counter
//   Up counter that sticks at all-ones.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     i_clear    : restart the count (takes precedence over i_up)
//     i_load_one : when restarting, start at 1 instead of 0
//     i_up       : increment by one unless already saturated
//     o_count    : current count
// ---------------------------------------------------------------------------
module rggen_saturating_counter #(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load_one,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // A restart that coincides with a new event must still record that
    // event, hence the load-one option instead of a plain clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= i_load_one ? WIDTH'(1) : '0;
        end else if (i_up && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rggen_bit_field_w01sc_event.sv
// ---------------------------------------------------------------------------
// rggen_bit_field_w01sc_event
//   Set/clear bit field with write-1 (or write-0) software control, sticky
//   overflow flags for lost hardware events, a saturating miss counter and
//   a registered interrupt.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     i_set_or_clear  : hardware set (CLEAR mode) or clear (SET mode) per bit
//     i_irq_enable    : per-bit interrupt enable
//     register_if     : bus view; this field drives read_data[MSB:LSB]
//     o_value         : field value
//     o_overflow      : sticky per-bit "event arrived while already set"
//     o_irq           : registered OR of enabled field bits
//     o_miss_count    : saturating count of cycles with a missed event
//   Build option:
//     RGGEN_BIT_FIELD_MISS_COUNTER_EN - when defined the miss counter is
//     built; otherwise o_miss_count is constant zero.
// ---------------------------------------------------------------------------
module rggen_bit_field_w01sc_event
    import rggen_rtl_pkg::*;
#(
    parameter rggen_rwsc_mode   MODE            = RGGEN_CLEAR_MODE,
    parameter bit               SET_CLEAR_VALUE = 1'b1,
    parameter int               MSB             = 0,
    parameter int               LSB             = 0,
    parameter logic [MSB-LSB:0] INITIAL_VALUE   = '0,
    parameter bit               SET_PRIORITY    = 1'b1,
    parameter int               COUNT_WIDTH     = 8
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MSB-LSB:0]       i_set_or_clear,
    input  logic [MSB-LSB:0]       i_irq_enable,
    rggen_register_if.data         register_if,
    output logic [MSB-LSB:0]       o_value,
    output logic [MSB-LSB:0]       o_overflow,
    output logic                   o_irq,
    output logic [COUNT_WIDTH-1:0] o_miss_count
);

    localparam int WIDTH      = MSB - LSB + 1;
    localparam bit CLEAR_MODE = (MODE == RGGEN_CLEAR_MODE);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_overflow;
    logic             r_irq;

    logic             w_writeAccess;
    logic [WIDTH-1:0] w_writeBits;
    logic [WIDTH-1:0] w_sw;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_miss;
    logic [WIDTH-1:0] w_nextValue;
    logic [WIDTH-1:0] w_nextOverflow;

    assign w_writeAccess = register_if.write_access();

    // Bits carrying the acting value; a mask of zero leaves the bit alone.
    assign w_writeBits = SET_CLEAR_VALUE ? register_if.write_data[MSB:LSB]
                                         : ~register_if.write_data[MSB:LSB];
    assign w_sw        = {WIDTH{w_writeAccess}} & register_if.write_mask[MSB:LSB] & w_writeBits;

    assign w_set   = CLEAR_MODE ? i_set_or_clear : w_sw;
    assign w_clear = CLEAR_MODE ? w_sw : i_set_or_clear;

    // Both forms agree away from collisions; they differ only on bits that
    // are set and cleared in the same cycle.
    assign w_nextValue = SET_PRIORITY ? (w_set | (r_value & ~w_clear))
                                      : ((w_set | r_value) & ~w_clear);

    // A miss is a hardware event landing on a bit software has not yet
    // acknowledged; a bit being acknowledged this cycle cannot miss.
    assign w_miss         = CLEAR_MODE ? (i_set_or_clear & r_value & ~w_sw) : '0;
    assign w_nextOverflow = CLEAR_MODE ? (w_miss | (r_overflow & ~w_sw)) : '0;

    // Field state; the interrupt is derived from the next value so it rises
    // in the same cycle the field bit becomes visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value    <= INITIAL_VALUE;
            r_overflow <= '0;
            r_irq      <= |(INITIAL_VALUE & i_irq_enable);
        end else begin
            r_value    <= w_nextValue;
            r_overflow <= w_nextOverflow;
            r_irq      <= |(w_nextValue & i_irq_enable);
        end
    end

    // Readback: only this field's slice carries data.
    always_comb begin
        register_if.read_data          = '0;
        register_if.read_data[MSB:LSB] = r_value;
    end

    assign o_value    = r_value;
    assign o_overflow = r_overflow;
    assign o_irq      = r_irq;

`ifdef RGGEN_BIT_FIELD_MISS_COUNTER_EN
    // Any software acknowledge restarts the count, keeping a miss that
    // happens in the very same cycle.
    rggen_saturating_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_missCounter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (|w_sw),
        .i_load_one (|w_miss),
        .i_up       (|w_miss),
        .o_count    (o_miss_count)
    );
`else
    assign o_miss_count = '0;
`endif

endmodule

// File: tb/tb_rggen_bit_field_w01sc_event.sv
// ---------------------------------------------------------------------------
// tb_rggen_bit_field_w01sc_event
//   Directed vectors against four field configurations and a stand-alone
//   2-bit saturating counter:
//     sel 0 : CLEAR mode, write-1, [3:0], set priority, reset 0
//     sel 1 : CLEAR mode, write-1, [3:0], clear priority, reset 0
//     sel 2 : CLEAR mode, write-1, [3:0], set priority, reset 4'hA
//     sel 3 : SET mode,   write-0, [7:4], set priority, reset 0
//     sel 4 : rggen_saturating_counter WIDTH=2 (hw = {load_one, clear, up})
//   Each vector carries its hand-computed result; stimulus queues it and a
//   monitor checks it one cycle later.
// ---------------------------------------------------------------------------
module tb_rggen_bit_field_w01sc_event;
    import rggen_rtl_pkg::*;

`ifdef RGGEN_BIT_FIELD_MISS_COUNTER_EN
    localparam bit COUNTER_EN = 1'b1;
`else
    localparam bit COUNTER_EN = 1'b0;
`endif

    typedef struct {
        int         id;
        int         sel;
        logic       rst;
        logic [3:0] hw;
        logic [3:0] en;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] wmask;
        logic [3:0] val;
        logic [3:0] ovf;
        logic       irq;
        logic [7:0] cnt;
    } vector_t;

    logic       clock;
    logic       reset;
    logic [3:0] hwIn   [4];
    logic [3:0] enIn   [4];
    logic [3:0] valOut [4];
    logic [3:0] ovfOut [4];
    logic       irqOut [4];
    logic [7:0] cntOut [4];
    logic       cntUp;
    logic       cntClear;
    logic       cntLoadOne;
    logic [1:0] cntCount;

    vector_t expQ[$];
    int      vectorsApplied = 0;
    int      compares       = 0;
    int      miscompares    = 0;

    rggen_register_if #(.DATA_WIDTH(8)) regIf0 ();
    rggen_register_if #(.DATA_WIDTH(8)) regIf1 ();
    rggen_register_if #(.DATA_WIDTH(8)) regIf2 ();
    rggen_register_if #(.DATA_WIDTH(8)) regIf3 ();

    rggen_bit_field_w01sc_event #(
        .MODE(RGGEN_CLEAR_MODE), .SET_CLEAR_VALUE(1'b1), .MSB(3), .LSB(0),
        .INITIAL_VALUE(4'h0), .SET_PRIORITY(1'b1), .COUNT_WIDTH(8)
    ) dut0 (
        .clk(clock), .rst(reset), .i_set_or_clear(hwIn[0]), .i_irq_enable(enIn[0]),
        .register_if(regIf0), .o_value(valOut[0]), .o_overflow(ovfOut[0]),
        .o_irq(irqOut[0]), .o_miss_count(cntOut[0])
    );

    rggen_bit_field_w01sc_event #(
        .MODE(RGGEN_CLEAR_MODE), .SET_CLEAR_VALUE(1'b1), .MSB(3), .LSB(0),
        .INITIAL_VALUE(4'h0), .SET_PRIORITY(1'b0), .COUNT_WIDTH(8)
    ) dut1 (
        .clk(clock), .rst(reset), .i_set_or_clear(hwIn[1]), .i_irq_enable(enIn[1]),
        .register_if(regIf1), .o_value(valOut[1]), .o_overflow(ovfOut[1]),
        .o_irq(irqOut[1]), .o_miss_count(cntOut[1])
    );

    rggen_bit_field_w01sc_event #(
        .MODE(RGGEN_CLEAR_MODE), .SET_CLEAR_VALUE(1'b1), .MSB(3), .LSB(0),
        .INITIAL_VALUE(4'hA), .SET_PRIORITY(1'b1), .COUNT_WIDTH(8)
    ) dut2 (
        .clk(clock), .rst(reset), .i_set_or_clear(hwIn[2]), .i_irq_enable(enIn[2]),
        .register_if(regIf2), .o_value(valOut[2]), .o_overflow(ovfOut[2]),
        .o_irq(irqOut[2]), .o_miss_count(cntOut[2])
    );

    rggen_bit_field_w01sc_event #(
        .MODE(RGGEN_SET_MODE), .SET_CLEAR_VALUE(1'b0), .MSB(7), .LSB(4),
        .INITIAL_VALUE(4'h0), .SET_PRIORITY(1'b1), .COUNT_WIDTH(8)
    ) dut3 (
        .clk(clock), .rst(reset), .i_set_or_clear(hwIn[3]), .i_irq_enable(enIn[3]),
        .register_if(regIf3), .o_value(valOut[3]), .o_overflow(ovfOut[3]),
        .o_irq(irqOut[3]), .o_miss_count(cntOut[3])
    );

    rggen_saturating_counter #(.WIDTH(2)) satCounter (
        .clk(clock), .rst(reset), .i_clear(cntClear), .i_load_one(cntLoadOne),
        .i_up(cntUp), .o_count(cntCount)
    );

    // Free-running clock; inputs change on the falling edge.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vector_t mk(input int sel, input logic rst,
                                   input logic [3:0] hw, input logic [3:0] en,
                                   input logic wr, input logic [7:0] wdata,
                                   input logic [7:0] wmask, input logic [3:0] val,
                                   input logic [3:0] ovf, input logic irq,
                                   input logic [7:0] cnt);
        vector_t v;
        v.id = 0; v.sel = sel; v.rst = rst; v.hw = hw; v.en = en; v.wr = wr;
        v.wdata = wdata; v.wmask = wmask; v.val = val; v.ovf = ovf;
        v.irq = irq; v.cnt = cnt;
        return v;
    endfunction

    task automatic idleAll();
        for (int i = 0; i < 4; i++) begin
            hwIn[i] = '0;
            enIn[i] = '0;
        end
        regIf0.valid = 1'b0; regIf0.write = 1'b0; regIf0.write_data = '0; regIf0.write_mask = '0;
        regIf1.valid = 1'b0; regIf1.write = 1'b0; regIf1.write_data = '0; regIf1.write_mask = '0;
        regIf2.valid = 1'b0; regIf2.write = 1'b0; regIf2.write_data = '0; regIf2.write_mask = '0;
        regIf3.valid = 1'b0; regIf3.write = 1'b0; regIf3.write_data = '0; regIf3.write_mask = '0;
        cntUp = 1'b0; cntClear = 1'b0; cntLoadOne = 1'b0;
    endtask

    // Drive one vector on the falling edge and queue its expected result.
    task automatic applyStimulus(input vector_t vIn);
        vector_t v;
        v = vIn;
        @(negedge clock);
        idleAll();
        reset = v.rst;
        if (v.sel < 4) begin
            hwIn[v.sel] = v.hw;
            enIn[v.sel] = v.en;
        end else begin
            cntUp      = v.hw[0];
            cntClear   = v.hw[1];
            cntLoadOne = v.hw[2];
        end
        case (v.sel)
            0: begin regIf0.valid = v.wr; regIf0.write = v.wr; regIf0.write_data = v.wdata; regIf0.write_mask = v.wmask; end
            1: begin regIf1.valid = v.wr; regIf1.write = v.wr; regIf1.write_data = v.wdata; regIf1.write_mask = v.wmask; end
            2: begin regIf2.valid = v.wr; regIf2.write = v.wr; regIf2.write_data = v.wdata; regIf2.write_mask = v.wmask; end
            3: begin regIf3.valid = v.wr; regIf3.write = v.wr; regIf3.write_data = v.wdata; regIf3.write_mask = v.wmask; end
            default: ;
        endcase
        v.id = vectorsApplied;
        vectorsApplied++;
        expQ.push_back(v);
    endtask

    task automatic checkField(input string name, input int id,
                              input logic [7:0] act, input logic [7:0] exp);
        compares++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s vec %0d: got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    // Compare the selected block's outputs against the queued expectation.
    task automatic checkOutput(input vector_t e);
        logic [3:0] readBack;
        case (e.sel)
            0:       readBack = regIf0.read_data[3:0];
            1:       readBack = regIf1.read_data[3:0];
            2:       readBack = regIf2.read_data[3:0];
            3:       readBack = regIf3.read_data[7:4];
            default: readBack = '0;
        endcase
        if (e.sel < 4) begin
            checkField("value",      e.id, {4'h0, valOut[e.sel]}, {4'h0, e.val});
            checkField("read_data",  e.id, {4'h0, readBack},      {4'h0, e.val});
            checkField("overflow",   e.id, {4'h0, ovfOut[e.sel]}, {4'h0, e.ovf});
            checkField("irq",        e.id, {7'h0, irqOut[e.sel]}, {7'h0, e.irq});
            checkField("miss_count", e.id, cntOut[e.sel], COUNTER_EN ? e.cnt : 8'h00);
        end else begin
            checkField("sat_count",  e.id, {6'h0, cntCount}, e.cnt);
        end
    endtask

    // Monitor: outputs settle after the rising edge that consumed a vector.
    always @(posedge clock) begin
        vector_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        reset = 1'b1;
        idleAll();

        // sel 0: basic set/clear, overflow and miss count, collision, irq, mask ignore
        applyStimulus(mk(0, 1, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0));
        applyStimulus(mk(0, 0, 4'b0101, 4'b0000, 0, 8'h00, 8'h00, 4'b0101, 4'b0000, 0, 0));
        applyStimulus(mk(0, 0, 4'b0000, 4'b0000, 1, 8'h01, 8'h0F, 4'b0100, 4'b0000, 0, 0));
        applyStimulus(mk(0, 0, 4'b0100, 4'b0000, 0, 8'h00, 8'h00, 4'b0100, 4'b0100, 0, 1));
        applyStimulus(mk(0, 0, 4'b0100, 4'b0000, 0, 8'h00, 8'h00, 4'b0100, 4'b0100, 0, 2));
        applyStimulus(mk(0, 0, 4'b0100, 4'b0000, 0, 8'h00, 8'h00, 4'b0100, 4'b0100, 0, 3));
        applyStimulus(mk(0, 0, 4'b0000, 4'b0000, 1, 8'h04, 8'h0F, 4'b0000, 4'b0000, 0, 0));
        applyStimulus(mk(0, 0, 4'b0001, 4'b0000, 1, 8'h01, 8'h0F, 4'b0001, 4'b0000, 0, 0));
        applyStimulus(mk(0, 0, 4'b0010, 4'b0010, 0, 8'h00, 8'h00, 4'b0011, 4'b0000, 1, 0));
        applyStimulus(mk(0, 0, 4'b0000, 4'b0010, 1, 8'h03, 8'h0F, 4'b0000, 4'b0000, 0, 0));
        applyStimulus(mk(0, 0, 4'b1000, 4'b0010, 0, 8'h00, 8'h00, 4'b1000, 4'b0000, 0, 0));
        applyStimulus(mk(0, 0, 4'b0000, 4'b0000, 1, 8'h08, 8'hF0, 4'b1000, 4'b0000, 0, 0));
        applyStimulus(mk(0, 0, 4'b1000, 4'b0000, 1, 8'h01, 8'h0F, 4'b1000, 4'b1000, 0, 1));
        applyStimulus(mk(0, 0, 4'b0000, 4'b0000, 1, 8'h08, 8'h0F, 4'b0000, 4'b0000, 0, 0));

        // sel 1: clear wins on collisions
        applyStimulus(mk(1, 1, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0));
        applyStimulus(mk(1, 0, 4'b0001, 4'b0000, 1, 8'h01, 8'h0F, 4'b0000, 4'b0000, 0, 0));
        applyStimulus(mk(1, 0, 4'b0010, 4'b0000, 0, 8'h00, 8'h00, 4'b0010, 4'b0000, 0, 0));
        applyStimulus(mk(1, 0, 4'b0101, 4'b0000, 1, 8'h06, 8'h0F, 4'b0001, 4'b0000, 0, 0));

        // sel 2: non-zero reset value, irq at reset, reset in the middle of activity
        applyStimulus(mk(2, 1, 4'b0000, 4'b0010, 0, 8'h00, 8'h00, 4'hA, 4'b0000, 1, 0));
        applyStimulus(mk(2, 0, 4'b0010, 4'b0000, 0, 8'h00, 8'h00, 4'hA, 4'b0010, 0, 1));
        applyStimulus(mk(2, 0, 4'b0010, 4'b0000, 0, 8'h00, 8'h00, 4'hA, 4'b0010, 0, 2));
        applyStimulus(mk(2, 1, 4'b0101, 4'b0000, 1, 8'h08, 8'h0F, 4'hA, 4'b0000, 0, 0));
        applyStimulus(mk(2, 0, 4'b0000, 4'b1000, 0, 8'h00, 8'h00, 4'hA, 4'b0000, 1, 0));

        // sel 3: SET mode, write-0, field at [7:4]
        applyStimulus(mk(3, 1, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0));
        applyStimulus(mk(3, 0, 4'b0000, 4'b0000, 1, 8'h0F, 8'hF0, 4'b1111, 4'b0000, 0, 0));
        applyStimulus(mk(3, 0, 4'b0011, 4'b0000, 0, 8'h00, 8'h00, 4'b1100, 4'b0000, 0, 0));
        applyStimulus(mk(3, 0, 4'b0000, 4'b0000, 1, 8'hF0, 8'hFF, 4'b1100, 4'b0000, 0, 0));
        applyStimulus(mk(3, 0, 4'b0000, 4'b0000, 1, 8'h00, 8'h0F, 4'b1100, 4'b0000, 0, 0));
        applyStimulus(mk(3, 0, 4'b1100, 4'b0000, 1, 8'hB0, 8'hF0, 4'b0100, 4'b0000, 0, 0));
        applyStimulus(mk(3, 0, 4'b0000, 4'b0100, 0, 8'h00, 8'h00, 4'b0100, 4'b0000, 1, 0));

        // sel 4: 2-bit counter saturation and restart
        applyStimulus(mk(4, 1, 4'b0000, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0));
        applyStimulus(mk(4, 0, 4'b0001, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 1));
        applyStimulus(mk(4, 0, 4'b0001, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 2));
        applyStimulus(mk(4, 0, 4'b0001, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 3));
        applyStimulus(mk(4, 0, 4'b0001, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 3));
        applyStimulus(mk(4, 0, 4'b0001, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 3));
        applyStimulus(mk(4, 0, 4'b0111, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 1));
        applyStimulus(mk(4, 0, 4'b0010, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 0));
        applyStimulus(mk(4, 0, 4'b0101, 4'b0000, 0, 8'h00, 8'h00, 4'b0000, 4'b0000, 0, 1));

        @(negedge clock);
        idleAll();
        for (int k = 0; k < 5 && expQ.size() > 0; k++) @(posedge clock);
        #2;
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("[TB] %0d comparisons made", compares);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
